if_fetch_unit: RTL

- Instruction-fetch stage of the 5-stage MIPS pipeline; sits directly upstream of the IF/ID pipeline register.
- Owns the program counter and issues word fetches to an instruction memory over a req/ack handshake. Memory latency is variable (0..N wait cycles).
- Presents {pc, pc+4, instruction, valid} to IF/ID.
- Honours stall from the hazard unit and branch/jump redirects from ID/EX, including redirects that arrive while a fetch is outstanding.

---
 rtl/if_fetch_unit_pkg.sv | 14 +
 rtl/if_fetch_unit_if.sv | 26 ++
 rtl/if_fetch_unit_fetch_pc_reg.sv | 31 +++
 rtl/if_fetch_unit.sv | 122 ++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states and the
// default program counter constants.
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h00400000;
  localparam logic [31:0] PC_INCR          = 32'h00000004;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage
// (master) and the instruction memory (slave).
interface if_fetch_unit_if #(
  parameter int NBits = 32
);

  logic             imem_req_o;
  logic [NBits-1:0] imem_addr_o;
  logic             imem_ack_i;
  logic [NBits-1:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ack_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ack_i,
    output imem_rdata_i
  );

endinterface

// File: rtl/if_fetch_unit_fetch_pc_reg.sv
// Program counter register: word-aligned load of a redirect target or a
// sequential +4 step, reset to the text segment base.
module fetch_pc_reg
  import if_fetch_unit_pkg::*;
#(
  parameter int               NBits    = 32,
  parameter logic [NBits-1:0] RESET_PC = NBits'(RESET_PC_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             incr,
  input  logic [NBits-1:0] target,
  output logic [NBits-1:0] pc
);

  localparam logic [NBits-1:0] ALIGN_MASK = ~NBits'(3);
  localparam logic [NBits-1:0] STEP       = NBits'(PC_INCR);

  // Load takes priority; the increment wraps naturally at 2^NBits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= target & ALIGN_MASK;
    end else if (incr) begin
      pc <= pc + STEP;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack bus and
// presents {pc, pc+4, instruction, valid} to the IF/ID register.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int               NBits    = 32,
  parameter logic [NBits-1:0] RESET_PC = NBits'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [NBits-1:0]      redirect_pc_i,
  if_fetch_unit_if.master       imem,
  output logic [NBits-1:0]      pc_o,
  output logic [NBits-1:0]      pc_plus_4_o,
  output logic [NBits-1:0]      instruction_o,
  output logic                  valid_o
);

  localparam logic [NBits-1:0] STEP = NBits'(PC_INCR);

  fetch_state_t     state;
  logic             req_r;
  logic             redirect_pending;
  logic [NBits-1:0] pending_pc;
  logic [NBits-1:0] pc_r;
  logic [NBits-1:0] pc_target;
  logic             pc_load;
  logic             pc_incr;

  assign imem.imem_req_o  = req_r;
  assign imem.imem_addr_o = pc_r;

  // The PC only moves at an ack or on a redirect outside FETCH, which keeps
  // the address stable for the whole life of an outstanding request.
  always_comb begin
    pc_load   = 1'b0;
    pc_incr   = 1'b0;
    pc_target = redirect_pc_i;
    case (state)
      IDLE: pc_load = redirect_i;
      FETCH: begin
        if (imem.imem_ack_i) begin
          if (redirect_i || redirect_pending) begin
            pc_load   = 1'b1;
            pc_target = redirect_i ? redirect_pc_i : pending_pc;
          end else begin
            pc_incr = 1'b1;
          end
        end
      end
      HOLD: pc_load = redirect_i;
      default: ;
    endcase
  end

  fetch_pc_reg #(
    .NBits    (NBits),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .reset  (reset),
    .load   (pc_load),
    .incr   (pc_incr),
    .target (pc_target),
    .pc     (pc_r)
  );

  // A redirect seen while waiting is parked until the ack, so the memory
  // transaction completes before the stale data is thrown away.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      req_r            <= 1'b0;
      valid_o          <= 1'b0;
      pc_o             <= '0;
      pc_plus_4_o      <= '0;
      instruction_o    <= '0;
      redirect_pending <= 1'b0;
      pending_pc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          req_r <= 1'b1;
        end
        FETCH: begin
          if (!imem.imem_ack_i) begin
            if (redirect_i) begin
              redirect_pending <= 1'b1;
              pending_pc       <= redirect_pc_i;
            end
          end else if (redirect_i || redirect_pending) begin
            redirect_pending <= 1'b0;
            req_r            <= 1'b1;
          end else begin
            instruction_o <= imem.imem_rdata_i;
            pc_o          <= pc_r;
            pc_plus_4_o   <= pc_r + STEP;
            valid_o       <= 1'b1;
            req_r         <= 1'b0;
            state         <= HOLD;
          end
        end
        HOLD: begin
          if (redirect_i || !stall_i) begin
            valid_o <= 1'b0;
            req_r   <= 1'b1;
            state   <= FETCH;
          end
        end
        default: begin
          state   <= IDLE;
          req_r   <= 1'b0;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
